// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings and the baud divider.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_e;

    // Clock cycles per serial bit, truncated.
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; resets to RESET_VAL.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling from a synchronized line, one-byte holding
// register with overrun and framing-error flags cleared by a read strobe.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned BAUD_RATE   = 115200
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_rx,
    input  logic        i_rd,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_overrun,
    output logic        o_frame_err,
    output uart_state_e o_state
);

    localparam int unsigned DIV = calc_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned CW  = (DIV < 4) ? 2 : $clog2(DIV);
    localparam logic [CW-1:0] RELOAD_FULL = CW'(DIV - 1);
    localparam logic [CW-1:0] RELOAD_HALF = CW'(DIV / 2 - 1);

    if (DIV < 4) begin : g_bad_div
        $error("uart_receiver: CLK_FREQ_HZ / BAUD_RATE must be at least 4");
    end

    logic rxs;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d_i    (i_rx),
        .q_o    (rxs)
    );

    uart_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [2:0]    idx_q,   idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q,  data_d;
    logic          valid_q, valid_d;
    logic          ovr_q,   ovr_d;
    logic          ferr_q,  ferr_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        ferr_d  = ferr_q;

        // A read clears the flags; a delivery or framing error in the same cycle wins below.
        if (i_rd) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
            ferr_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    state_d = ST_START;
                    cnt_d   = RELOAD_HALF;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    if (!rxs) begin
                        state_d = ST_DATA;
                        cnt_d   = RELOAD_FULL;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rxs, shift_q[7:1]};
                    cnt_d   = RELOAD_FULL;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (rxs) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        if (valid_q && !i_rd) begin
                            ovr_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_overrun   = ovr_q;
    assign o_frame_err = ferr_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at DIV=16: table of back-to-back frames plus
// hand-written sequences for latency, glitch, framing error, reset and read/delivery collision.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int unsigned CLK_HZ = 1_600_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int          DIV    = 16;

    logic        clk;
    logic        resetn;
    logic        rx;
    logic        rd;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_overrun;
    logic        o_frame_err;
    uart_state_e o_state;

    int checks = 0;
    int errors = 0;

    uart_receiver #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .i_rx        (rx),
        .i_rd        (rd),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_overrun   (o_overrun),
        .o_frame_err (o_frame_err),
        .o_state     (o_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard helper
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drivers (all changes on the falling clock edge)
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic [7:0] d, input logic v,
                               input logic ov, input logic fe);
        check({tag, "_data"},  32'(o_data),      32'(d));
        check({tag, "_valid"}, 32'(o_valid),     32'(v));
        check({tag, "_ovr"},   32'(o_overrun),   32'(ov));
        check({tag, "_ferr"},  32'(o_frame_err), 32'(fe));
    endtask

    typedef struct {
        logic [7:0] tx;
        logic       rd_after;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_ovr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat;
        int n;

        vecs[0] = '{tx: 8'hA3, rd_after: 1'b0, exp_data: 8'hA3, exp_valid: 1'b1, exp_ovr: 1'b0, exp_ferr: 1'b0};
        vecs[1] = '{tx: 8'h0F, rd_after: 1'b1, exp_data: 8'h0F, exp_valid: 1'b1, exp_ovr: 1'b1, exp_ferr: 1'b0};
        vecs[2] = '{tx: 8'h00, rd_after: 1'b0, exp_data: 8'h00, exp_valid: 1'b1, exp_ovr: 1'b0, exp_ferr: 1'b0};
        vecs[3] = '{tx: 8'hFF, rd_after: 1'b1, exp_data: 8'hFF, exp_valid: 1'b1, exp_ovr: 1'b1, exp_ferr: 1'b0};
        vecs[4] = '{tx: 8'h81, rd_after: 1'b1, exp_data: 8'h81, exp_valid: 1'b1, exp_ovr: 1'b0, exp_ferr: 1'b0};
        vecs[5] = '{tx: 8'h5A, rd_after: 1'b0, exp_data: 8'h5A, exp_valid: 1'b1, exp_ovr: 1'b0, exp_ferr: 1'b0};

        // Reset state
        resetn = 1'b0;
        rx     = 1'b1;
        rd     = 1'b0;
        repeat (3) @(negedge clk);
        check_flags("reset_hold", 8'h00, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check_flags("reset_rel", 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset_state", 32'(o_state), 32'(ST_IDLE));

        // 0x55 with latency measured from the start edge
        lat = 0;
        fork
            send_frame(8'h55, 1'b1);
            begin
                while (!o_valid && lat < 300) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check("latency_in_154pm1", 32'(lat >= 153 && lat <= 155), 32'd1);
        check_flags("f55", 8'h55, 1'b1, 1'b0, 1'b0);
        pulse_rd();
        check_flags("f55_rd", 8'h55, 1'b0, 1'b0, 1'b0);

        // Start-bit glitch
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_in_start", 32'(o_state), 32'(ST_START));
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_state", 32'(o_state), 32'(ST_IDLE));
        check("glitch_valid", 32'(o_valid), 32'd0);

        // Table of back-to-back frames
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].tx, 1'b1);
            check_flags($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_valid,
                        vecs[i].exp_ovr, vecs[i].exp_ferr);
            if (vecs[i].rd_after) begin
                pulse_rd();
                check_flags($sformatf("vec%0d_rd", i), vecs[i].exp_data, 1'b0, 1'b0, 1'b0);
            end
        end

        // Framing error with a long break, then recovery
        pulse_rd();
        send_frame(8'hFF, 1'b0);
        repeat (40) @(negedge clk);
        check("break_state", 32'(o_state), 32'(ST_WAIT_HIGH));
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("break_idle", 32'(o_state), 32'(ST_IDLE));
        check_flags("ferr", 8'h5A, 1'b0, 1'b0, 1'b1);
        pulse_rd();
        check("ferr_rd_clear", 32'(o_frame_err), 32'd0);
        send_frame(8'h3C, 1'b1);
        check_flags("after_ferr", 8'h3C, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset during data bit 3
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = (i == 0 || i == 1) ? 1'b0 : 1'b1;
            repeat (DIV) @(negedge clk);
        end
        rx = 1'b1;
        repeat (DIV / 2) @(negedge clk);
        check("pre_reset_state", 32'(o_state), 32'(ST_DATA));
        #2;
        resetn = 1'b0;
        #1;
        check_flags("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        check("async_rst_state", 32'(o_state), 32'(ST_IDLE));
        @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_no_byte", 32'(o_valid), 32'd0);
        check("post_rst_state", 32'(o_state), 32'(ST_IDLE));
        send_frame(8'h3C, 1'b1);
        check_flags("post_rst_3c", 8'h3C, 1'b1, 1'b0, 1'b0);

        // Read strobe on the same cycle as delivery of 0x81 while a byte is held
        n = 0;
        fork
            send_frame(8'h81, 1'b1);
            begin
                while (o_state != ST_STOP && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                check("collide_stop_seen", 32'(n < 400), 32'd1);
                if (n < 400) begin
                    repeat (DIV - 1) @(negedge clk);
                    rd = 1'b1;
                    @(negedge clk);
                    rd = 1'b0;
                end
            end
        join
        check_flags("collide", 8'h81, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
